read_buffer_fifo: RTL and testbench
===================================

// Module: read_buffer_fifo
// PURPOSE
//  Circular data buffer that sits directly upstream of the read-buffer controller.
//  - Producer side: the external memory/loader pushes words with wr_en.
//  - Consumer side: the controller holds read_req high until it sees a 1-cycle valid
//    pulse carrying rd_data, which it then writes into the scratchpad.
//  - Provides occupancy, full/empty and sticky overflow status to the top-level control.
// PARAMETERS
//  DATA_W  16  width of one buffered word
//  DEPTH   16  number of entries; power of two, >= 2
//  PTR_W   $clog2(DEPTH)    read/write pointer width (derived, do not override)
//  CNT_W   $clog2(DEPTH+1)  occupancy counter width (derived, do not override)
// PORTS
//  clk        in   1       system clock, all logic on rising edge
//  rst        in   1       synchronous, active-low reset
//  flush      in   1       synchronous active-high clear (driven by inner_rst), same effect as rst
//  wr_en      in   1       push wr_data this cycle
//  wr_data    in   DATA_W  word to push
//  read_req   in   1       level request from controller; held until valid seen
//  valid      out  1       registered, 1-cycle pulse: rd_data is the popped word
//  rd_data    out  DATA_W  registered data; holds last popped word when valid=0
//  full       out  1       count == DEPTH
//  empty      out  1       count == 0
//  count      out  CNT_W   current occupancy
//  overflow   out  1       sticky: a push was attempted while full
// BEHAVIOUR
//  Reset (rst==0 at edge) or flush==1:
//  - rd_ptr=wr_ptr=0, count=0, valid=0, rd_data=0, overflow=0.
//  - Memory contents are not cleared. rst has priority over all other inputs.
//  Push:
//  - Accepted iff wr_en && !full (full sampled pre-edge): mem[wr_ptr]<=wr_data, wr_ptr++.
//  - wr_en && full: word dropped, overflow<=1 (cleared only by rst/flush).
//  Pop:
//  - Fires iff read_req && !empty && !valid: rd_data<=mem[rd_ptr], rd_ptr++, valid<=1 next cycle.
//  - The !valid term prevents a double pop in the valid cycle, when read_req is still high.
//  - Latency read_req->valid = 1 cycle when not empty.
//  - Back-to-back requests yield at most one valid every 2 cycles.
//  - Empty: no pop, valid=0; read_req may stay high indefinitely.
//  - Push into empty buffer -> earliest valid 2 cycles after the wr_en edge (no bypass).
//  - read_req dropped while empty: no pending state is kept.
//  Simultaneous push+pop:
//  - Both fire, count unchanged.
//  - When full, pop fires, push is rejected (full is pre-edge) and sets overflow.
//  count: +1 on push only, -1 on pop only, never exceeds DEPTH or drops below 0.
//  Pointers wrap modulo DEPTH (natural PTR_W overflow).
//  flush asserted during the valid cycle: valid deasserts next cycle, the word is not replayed.
//  full, empty and count are combinational from registered state only; no comb path from inputs.
// STRUCTURE
//  Shared package cnn_buf_pkg: DATA_W/DEPTH defaults, derived-width functions.
//  One natural sub-module, buf_mem_dp: DEPTH x DATA_W register array.
//  - 1 synchronous write port, 1 registered read port.
//  - No reset on storage.
//  Pointer, counter and handshake logic stays in read_buffer_fifo.
// TESTING
//  1 Reset: rst=0 for 2 cycles with wr_en=1 -> count=0, empty=1, valid=0, overflow=0
//    after release.
//  2 Push 0x0011,0x0022,0x0033; hold read_req -> valid pulses on 3 separate cycles
//    carrying 0x0011,0x0022,0x0033, never 2 consecutive; then empty=1.
//  3 Fill DEPTH=16 words, push 0xBEEF -> full=1, overflow=1, count=16.
//    Drain all 16 -> original data in order, 0xBEEF absent.
//  4 read_req high while empty for 5 cycles, then push 0x00A5 at cycle t
//    -> valid=1 with rd_data=0x00A5 at cycle t+2, exactly once.
//  5 count=16 (full), wr_en=1 and read_req=1 same cycle -> pop occurs, push dropped,
//    count=15, overflow=1. 4 wrap-around rounds of 12 push/12 pop keep data order intact.
//  6 Push 4 words, assert flush in the cycle valid=1 -> next cycle count=0, valid=0,
//    no further valid while read_req held.

Source files
------------

// File: rtl/cnn_buf_pkg.sv
// ============================================================================
// Module  : cnn_buf_pkg
// Brief   : Shared defaults and derived-width helpers for the read buffer.
// Revision: 1.0
// ============================================================================
`default_nettype none

package cnn_buf_pkg;

    localparam int BUF_DATA_W = 16;
    localparam int BUF_DEPTH  = 16;

    function automatic int ptr_width(input int depth);
        return $clog2(depth);
    endfunction

    // One extra code point so a full buffer (count == depth) is representable.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/buf_mem_dp.sv
// ============================================================================
// Module  : buf_mem_dp
// Brief   : DEPTH x DATA_W register array, one sync write port, one registered read port.
// Revision: 1.0
// ============================================================================
`default_nettype none

module buf_mem_dp #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 16,
    parameter int PTR_W  = 4
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              wr_en,
    input  logic [PTR_W-1:0]  wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [PTR_W-1:0]  rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rd_data;

    // Storage is deliberately left unreset; only the read register clears.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            r_rd_data <= '0;
        end else if (rd_en) begin
            r_rd_data <= r_mem[rd_addr];
        end
    end

    assign rd_data = r_rd_data;

endmodule

`default_nettype wire

// File: rtl/read_buffer_fifo.sv
// ============================================================================
// Module  : read_buffer_fifo
// Brief   : Circular buffer feeding the read-buffer controller with 1-cycle valid pulses.
// Revision: 1.0
// ============================================================================
`default_nettype none

module read_buffer_fifo
    import cnn_buf_pkg::*;
#(
    parameter  int DATA_W = BUF_DATA_W,
    parameter  int DEPTH  = BUF_DEPTH,
    localparam int PTR_W  = ptr_width(DEPTH),
    localparam int CNT_W  = cnt_width(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              read_req,
    output logic              valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              full,
    output logic              empty,
    output logic [CNT_W-1:0]  count,
    output logic              overflow
);

    localparam logic [CNT_W-1:0] C_FULL_CNT = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] C_PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_valid;
    logic             r_overflow;

    logic w_clr;
    logic w_push;
    logic w_pop;

    assign w_clr  = !rst || flush;
    assign full   = (r_count == C_FULL_CNT);
    assign empty  = (r_count == '0);
    assign w_push = wr_en && !full;
    // Blocking the pop while valid is high stops a held read_req from popping twice.
    assign w_pop  = read_req && !empty && !r_valid;

    always_ff @(posedge clk) begin
        if (w_clr) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_valid    <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_valid <= w_pop;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + C_CNT_ONE;
                2'b01:   r_count <= r_count - C_CNT_ONE;
                default: r_count <= r_count;
            endcase
            if (wr_en && full) begin
                r_overflow <= 1'b1;
            end
        end
    end

    buf_mem_dp #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .PTR_W  (PTR_W)
    ) u_mem (
        .clk     (clk),
        .clr     (w_clr),
        .wr_en   (w_push && !w_clr),
        .wr_addr (r_wr_ptr),
        .wr_data (wr_data),
        .rd_en   (w_pop && !w_clr),
        .rd_addr (r_rd_ptr),
        .rd_data (rd_data)
    );

    assign valid    = r_valid;
    assign count    = r_count;
    assign overflow = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_read_buffer_fifo.sv
// ============================================================================
// Module  : tb_read_buffer_fifo
// Brief   : Directed and random stimulus checked against a queue-based buffer model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_read_buffer_fifo;

    localparam int DW = 16;
    localparam int DP = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          flush = 1'b0;
    logic          wr_en = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic          read_req = 1'b0;
    logic          valid;
    logic [DW-1:0] rd_data;
    logic          full;
    logic          empty;
    logic [4:0]    count;
    logic          overflow;

    int checks   = 0;
    int failures = 0;

    // Reference state: contents in order, last popped word, pending pulse, sticky flag.
    logic [DW-1:0] q[$];
    logic [DW-1:0] exp_rd   = '0;
    logic          exp_vld  = 1'b0;
    logic          exp_ovf  = 1'b0;

    read_buffer_fifo #(.DATA_W(DW), .DEPTH(DP)) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .read_req (read_req),
        .valid    (valid),
        .rd_data  (rd_data),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic w, input logic [DW-1:0] d, input logic r,
                        input logic f, input logic rs);
        bit was_full;
        bit was_empty;
        bit pop;
        wr_en    = w;
        wr_data  = d;
        read_req = r;
        flush    = f;
        rst      = rs;
        if (!rs || f) begin
            q.delete();
            exp_rd  = '0;
            exp_vld = 1'b0;
            exp_ovf = 1'b0;
        end else begin
            was_full  = (q.size() == DP);
            was_empty = (q.size() == 0);
            pop = r && !was_empty && !exp_vld;
            if (pop) exp_rd = q.pop_front();
            exp_vld = pop;
            if (w && was_full) exp_ovf = 1'b1;
            if (w && !was_full) q.push_back(d);
        end
        @(posedge clk);
        #1;
        chk("valid",    32'(valid),    32'(exp_vld));
        chk("rd_data",  32'(rd_data),  32'(exp_rd));
        chk("count",    32'(count),    32'(q.size()));
        chk("full",     32'(full),     32'(q.size() == DP));
        chk("empty",    32'(empty),    32'(q.size() == 0));
        chk("overflow", 32'(overflow), 32'(exp_ovf));
    endtask

    initial begin
        // Reset held with a push request
        step(1'b1, 16'h1234, 1'b0, 1'b0, 1'b0);
        step(1'b1, 16'h5678, 1'b0, 1'b0, 1'b0);
        step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
        chk("reset_empty", 32'(empty), 32'd1);
        chk("reset_count", 32'(count), 32'd0);

        // Three pushes then held request
        step(1'b1, 16'h0011, 1'b0, 1'b0, 1'b1);
        step(1'b1, 16'h0022, 1'b0, 1'b0, 1'b1);
        step(1'b1, 16'h0033, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) step(1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
        chk("t2_empty", 32'(empty), 32'd1);

        // Fill, overflow push, drain
        for (int i = 0; i < DP; i++) step(1'b1, 16'(16'h0100 + i), 1'b0, 1'b0, 1'b1);
        step(1'b1, 16'hBEEF, 1'b0, 1'b0, 1'b1);
        chk("t3_full", 32'(full), 32'd1);
        chk("t3_ovf", 32'(overflow), 32'd1);
        for (int i = 0; i < 2 * DP + 2; i++) step(1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);

        // Request while empty, then a late push
        step(1'b0, 16'h0000, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
        step(1'b1, 16'h00A5, 1'b1, 1'b0, 1'b1);
        step(1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
        chk("t4_valid", 32'(valid), 32'd1);
        chk("t4_data", 32'(rd_data), 32'h00A5);
        for (int i = 0; i < 4; i++) step(1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);

        // Simultaneous push+pop at full, then wrap-around rounds
        for (int i = 0; i < DP; i++) step(1'b1, 16'(16'h0200 + i), 1'b0, 1'b0, 1'b1);
        step(1'b1, 16'hDEAD, 1'b1, 1'b0, 1'b1);
        chk("t5_count", 32'(count), 32'd15);
        for (int i = 0; i < 2 * DP + 2; i++) step(1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
        for (int rd = 0; rd < 4; rd++) begin
            for (int i = 0; i < 12; i++) step(1'b1, 16'($urandom), 1'b0, 1'b0, 1'b1);
            for (int i = 0; i < 26; i++) step(1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
        end

        // Flush during the valid cycle
        step(1'b0, 16'h0000, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b1, 16'(16'h0300 + i), 1'b0, 1'b0, 1'b1);
        step(1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
        chk("t6_valid_before", 32'(valid), 32'd1);
        step(1'b0, 16'h0000, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);

        // Random traffic with occasional flush and reset
        for (int i = 0; i < 600; i++) begin
            step(1'($urandom_range(0, 99) < 55), 16'($urandom), 1'($urandom_range(0, 99) < 50),
                 1'($urandom_range(0, 99) == 0), 1'($urandom_range(0, 199) != 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
